ids_generator: RTL and testbench

- Synthesizable insertion/deletion/substitution (IDS) channel model for the DNA-coding datapath.
- Each clock it takes a k-bit codeword and independently corrupts every bit with insertion, deletion or substitution, using per-bit probabilities.
- It outputs the corrupted word, LSB-packed, together with its actual length.
- Used as the noisy-channel stage between encoder and decoder in simulation and FPGA test.

---
 rtl/ids_pkg.sv | 32 +++
 rtl/ids_prng_lane.sv | 20 ++
 rtl/ids_generator.sv | 127 ++++++++++++
 tb/tb_ids_generator.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ids_pkg.sv
// rtl/ids_pkg.sv - shared constants, event type and PRNG step for the IDS channel model
package ids_pkg;

  localparam logic [7:0]  PI_DEFAULT   = 8'd2;
  localparam logic [7:0]  PD_DEFAULT   = 8'd2;
  localparam logic [7:0]  PS_DEFAULT   = 8'd2;
  localparam logic [63:0] SEED_DEFAULT = 64'h9E3779B97F4A7C15;
  localparam logic [63:0] LANE_MIX     = 64'hD1B54A32D192ED03;

  typedef enum logic [1:0] {
    TRANSMIT = 2'd0,
    INSERT   = 2'd1,
    DELETE   = 2'd2,
    SUBST    = 2'd3
  } ids_event_e;

  function automatic logic [63:0] xorshift64_next(input logic [63:0] s);
    logic [63:0] x;
    x = s ^ (s << 13);
    x = x ^ (x >> 7);
    x = x ^ (x << 17);
    return x;
  endfunction

  // An all-zero xorshift state never leaves zero, so a colliding lane falls back to the mix constant.
  function automatic logic [63:0] lane_seed(input logic [63:0] seed, input int unsigned lane);
    logic [63:0] s;
    s = seed ^ (64'(lane) * LANE_MIX);
    return (s == 64'd0) ? LANE_MIX : s;
  endfunction

endpackage

// File: rtl/ids_prng_lane.sv
// rtl/ids_prng_lane.sv - one xorshift64 lane, advancing once per clock out of reset
module ids_prng_lane
  import ids_pkg::*;
#(
  parameter logic [63:0] SEED = SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [63:0] rnd
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd <= SEED;
    end else begin
      rnd <= xorshift64_next(rnd);
    end
  end

endmodule

// File: rtl/ids_generator.sv
// rtl/ids_generator.sv - per-bit insertion/deletion/substitution channel with registered packed output
module ids_generator
  import ids_pkg::*;
#(
  parameter logic [7:0]  pi         = PI_DEFAULT,
  parameter logic [7:0]  pd         = PD_DEFAULT,
  parameter logic [7:0]  ps         = PS_DEFAULT,
  parameter int          k          = 5,
  parameter int          DATA_WIDTH = 32,
  parameter int          ZERO       = 0,
  parameter logic [63:0] SEED       = SEED_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [k-1:0]          data_in,
  output logic [31:0]           n_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int OW = $clog2(2 * k + 1);

  localparam logic [8:0] T_INS = {1'b0, pi};
  localparam logic [8:0] T_DEL = T_INS + {1'b0, pd};
  localparam logic [8:0] T_SUB = T_DEL + {1'b0, ps};

  if (DATA_WIDTH < 2 * k) begin : g_chk_width
    $error("ids_generator: DATA_WIDTH must be at least 2*k");
  end
  if (int'(pi) + int'(pd) + int'(ps) > 256) begin : g_chk_prob
    $error("ids_generator: pi+pd+ps must not exceed 256");
  end
  if (SEED == 64'd0) begin : g_chk_seed
    $error("ids_generator: SEED must be non-zero");
  end

  logic [63:0] rnd [k];

  for (genvar gi = 0; gi < k; gi++) begin : g_lane
    ids_prng_lane #(
      .SEED(lane_seed(SEED, gi))
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .rnd  (rnd[gi])
    );
  end

  ids_event_e            ev     [k];
  logic       [1:0]      pat    [k];
  logic       [1:0]      len    [k];
  logic       [OW-1:0]   offset [k+1];
  logic [DATA_WIDTH-1:0] data_nxt;
  logic                  unused_rnd_hi;

  always_comb begin
    for (int i = 0; i < k; i++) begin
      if ({1'b0, rnd[i][7:0]} < T_INS) begin
        ev[i] = INSERT;
      end else if ({1'b0, rnd[i][7:0]} < T_DEL) begin
        ev[i] = DELETE;
      end else if ({1'b0, rnd[i][7:0]} < T_SUB) begin
        ev[i] = SUBST;
      end else begin
        ev[i] = TRANSMIT;
      end
    end
  end

  // pat[i] holds the bits bit i emits in output order, first emitted bit in pat[i][0].
  always_comb begin
    for (int i = 0; i < k; i++) begin
      pat[i] = 2'b00;
      len[i] = 2'd0;
      case (ev[i])
        INSERT: begin
          pat[i] = {data_in[i], (ZERO != 0) ? 1'b0 : rnd[i][8]};
          len[i] = 2'd2;
        end
        DELETE: begin
          pat[i] = 2'b00;
          len[i] = 2'd0;
        end
        SUBST: begin
          pat[i] = {1'b0, ~data_in[i]};
          len[i] = 2'd1;
        end
        default: begin
          pat[i] = {1'b0, data_in[i]};
          len[i] = 2'd1;
        end
      endcase
    end
  end

  always_comb begin
    offset[0] = '0;
    for (int i = 0; i < k; i++) begin
      offset[i+1] = offset[i] + {{(OW-2){1'b0}}, len[i]};
    end
  end

  // Unemitted pattern bits are zero, so OR-ing shifted patterns keeps positions >= n_out clear.
  always_comb begin
    data_nxt = '0;
    for (int i = 0; i < k; i++) begin
      data_nxt = data_nxt | ({{(DATA_WIDTH-2){1'b0}}, pat[i]} << offset[i]);
    end
  end

  always_comb begin
    unused_rnd_hi = 1'b0;
    for (int i = 0; i < k; i++) begin
      unused_rnd_hi = unused_rnd_hi ^ (^rnd[i][63:9]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      n_out    <= '0;
    end else begin
      data_out <= data_nxt;
      n_out    <= 32'(offset[k]);
    end
  end

endmodule

// File: tb/tb_ids_generator.sv
// tb/tb_ids_generator.sv - directed vectors and reference-model checks for ids_generator
module tb_ids_generator;

  localparam int K = 5;
  localparam logic [63:0] T_SEED = 64'h9E3779B97F4A7C15;
  localparam logic [63:0] T_MIX  = 64'hD1B54A32D192ED03;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  data_in = 5'd0;

  logic [31:0] n_def, n_clean, n_del, n_sub, n_ins;
  logic [31:0] d_def, d_clean, d_del, d_sub, d_ins;

  always #5 clk = ~clk;

  ids_generator u_def (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .n_out(n_def), .data_out(d_def));
  ids_generator #(.pi(8'd0), .pd(8'd0), .ps(8'd0)) u_clean (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .n_out(n_clean), .data_out(d_clean));
  ids_generator #(.pi(8'd0), .pd(8'd255), .ps(8'd0)) u_del (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .n_out(n_del), .data_out(d_del));
  ids_generator #(.pi(8'd0), .pd(8'd0), .ps(8'd128)) u_sub (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .n_out(n_sub), .data_out(d_sub));
  ids_generator #(.pi(8'd255), .pd(8'd0), .ps(8'd0), .ZERO(1)) u_ins (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .n_out(n_ins), .data_out(d_ins));

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [63:0] lane [K];
  logic [31:0] ed_def, ed_clean, ed_del, ed_sub, ed_ins;
  int          en_def, en_clean, en_del, en_sub, en_ins;
  int          mm_def = 0, mm_clean = 0, mm_del = 0, mm_sub = 0, mm_ins = 0;

  typedef struct {
    logic [4:0]  din;
    logic [31:0] exp_data;
    int          exp_n;
  } vec_t;
  vec_t vecs [8];

  logic [31:0] rec_d [300];
  logic [31:0] rec_n [300];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    total_cnt++;
    if (act >= lo && act <= hi) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  function automatic logic [63:0] xs64(input logic [63:0] x);
    logic [63:0] y;
    y = x ^ (x << 13);
    y = y ^ (y >> 7);
    y = y ^ (y << 17);
    return y;
  endfunction

  task automatic reseed();
    logic [63:0] s;
    for (int i = 0; i < K; i++) begin
      s = T_SEED ^ (64'(i) * T_MIX);
      lane[i] = (s == 64'd0) ? T_MIX : s;
    end
  endtask

  // Bit-serial channel: walk the input LSB first and append emitted bits at position n.
  function automatic void model(input int p_i, input int p_d, input int p_s, input int z,
                                input logic [4:0] d, output logic [31:0] dout, output int n);
    int r;
    n = 0;
    dout = '0;
    for (int i = 0; i < K; i++) begin
      r = int'(lane[i][7:0]);
      if (r < p_i) begin
        dout[n] = (z != 0) ? 1'b0 : lane[i][8];
        dout[n+1] = d[i];
        n = n + 2;
      end else if (r < p_i + p_d) begin
        n = n + 0;
      end else if (r < p_i + p_d + p_s) begin
        dout[n] = ~d[i];
        n = n + 1;
      end else begin
        dout[n] = d[i];
        n = n + 1;
      end
    end
  endfunction

  task automatic tick();
    model(2, 2, 2, 0, data_in, ed_def, en_def);
    model(0, 0, 0, 0, data_in, ed_clean, en_clean);
    model(0, 255, 0, 0, data_in, ed_del, en_del);
    model(0, 0, 128, 0, data_in, ed_sub, en_sub);
    model(255, 0, 0, 1, data_in, ed_ins, en_ins);
    for (int i = 0; i < K; i++) lane[i] = xs64(lane[i]);
    @(posedge clk);
    @(negedge clk);
    if (d_def !== ed_def || n_def !== 32'(en_def)) mm_def++;
    if (d_clean !== ed_clean || n_clean !== 32'(en_clean)) mm_clean++;
    if (d_del !== ed_del || n_del !== 32'(en_del)) mm_del++;
    if (d_sub !== ed_sub || n_sub !== 32'(en_sub)) mm_sub++;
    if (d_ins !== ed_ins || n_ins !== 32'(en_ins)) mm_ins++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    reseed();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    longint sum_def = 0, sum_del = 0, ones_sub = 0;
    int bad_def = 0, bad_clean = 0, bad_sub = 0, bad_del = 0, bad_ins = 0, good_ins = 0;
    int diffs = 0;

    vecs[0] = '{5'd0,  32'h0000_0000, 5};
    vecs[1] = '{5'd13, 32'h0000_000D, 5};
    vecs[2] = '{5'd31, 32'h0000_001F, 5};
    vecs[3] = '{5'd1,  32'h0000_0001, 5};
    vecs[4] = '{5'd16, 32'h0000_0010, 5};
    vecs[5] = '{5'd21, 32'h0000_0015, 5};
    vecs[6] = '{5'd10, 32'h0000_000A, 5};
    vecs[7] = '{5'd30, 32'h0000_001E, 5};

    rst_n = 1'b0;
    data_in = 5'd13;
    reseed();
    repeat (2) @(negedge clk);
    check("reset_def_data", d_def, 0);
    check("reset_def_n", n_def, 0);
    check("reset_ins_data", d_ins, 0);
    check("reset_ins_n", n_ins, 0);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      data_in = vecs[v].din;
      tick();
      check($sformatf("clean_data_%0d", v), d_clean, vecs[v].exp_data);
      check($sformatf("clean_n_%0d", v), n_clean, 64'(vecs[v].exp_n));
    end

    data_in = 5'd13;
    for (int c = 0; c < 10000; c++) begin
      tick();
      sum_def += longint'(n_def);
      if (n_def > 32'd10 || (d_def >> n_def) != 32'd0) bad_def++;
      if (d_clean !== 32'd13 || n_clean !== 32'd5) bad_clean++;
      if (n_sub !== 32'd5 || d_sub[31:5] !== 27'd0) bad_sub++;
      ones_sub += longint'($countones(d_sub[4:0] ^ 5'b01101));
      if (n_del > 32'd10 || (d_del >> n_del) != 32'd0) bad_del++;
      sum_del += longint'(n_del);
    end
    check("def_range_tail_viol", 64'(bad_def), 0);
    check("clean_steady_viol", 64'(bad_clean), 0);
    check("sub_len_tail_viol", 64'(bad_sub), 0);
    check("del_tail_viol", 64'(bad_del), 0);
    check_range("def_sum_n", sum_def, 49000, 51000);
    check_range("sub_flipped_bits", ones_sub, 22500, 27500);
    check_range("del_sum_n", sum_del, 97, 293);

    data_in = 5'b11111;
    for (int c = 0; c < 2000; c++) begin
      tick();
      if ($countones(d_ins) != 5 || (d_ins >> n_ins) != 32'd0) bad_ins++;
      if (n_ins == 32'd10 && d_ins == 32'h0000_02AA) good_ins++;
    end
    check("ins_ones_viol", 64'(bad_ins), 0);
    check_range("ins_full_cycles", longint'(good_ins), 1800, 2000);

    data_in = 5'd13;
    repeat (20) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_def_data", d_def, 0);
    check("async_reset_def_n", n_def, 0);
    check("async_reset_clean_n", n_clean, 0);
    reseed();
    @(negedge clk);
    rst_n = 1'b1;

    for (int c = 0; c < 300; c++) begin
      data_in = 5'(c);
      tick();
      rec_d[c] = d_def;
      rec_n[c] = n_def;
    end
    do_reset();
    for (int c = 0; c < 300; c++) begin
      data_in = 5'(c);
      tick();
      if (d_def !== rec_d[c] || n_def !== rec_n[c]) diffs++;
    end
    check("determinism_diffs", 64'(diffs), 0);

    check("model_def_mismatch", 64'(mm_def), 0);
    check("model_clean_mismatch", 64'(mm_clean), 0);
    check("model_del_mismatch", 64'(mm_del), 0);
    check("model_sub_mismatch", 64'(mm_sub), 0);
    check("model_ins_mismatch", 64'(mm_ins), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
